clock_time_counter: RTL and testbench

CLOCK_TIME_COUNTER -- requirements
Module: clock_time_counter

---
 rtl/clock_pkg.sv | 19 +
 rtl/mod_counter.sv | 33 +++
 rtl/clock_time_counter.sv | 131 +++++++++++++
 tb/tb_clock_time_counter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared definitions for the time-of-day counter: FSM states, time constants, field widths.
package clock_pkg;

  typedef enum logic [1:0] {
    STOP,
    RUN,
    LOAD
  } state_e;

  localparam int unsigned SEC_PER_MIN  = 60;
  localparam int unsigned MIN_PER_HOUR = 60;
  // Clock cycles per second expected of the upstream remainder stage.
  localparam int unsigned DIVISOR      = 20000000;

  localparam int unsigned HOUR_W = 5;
  localparam int unsigned MIN_W  = 6;
  localparam int unsigned SEC_W  = 6;

endpackage

// File: rtl/mod_counter.sv
// Modulus counter with synchronous load; wrap flags the increment that rolls MODULUS-1 to 0.
module mod_counter #(
  parameter int unsigned MODULUS = 60,
  parameter int unsigned WIDTH   = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] value,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] r_value;

  assign value = r_value;
  assign wrap  = inc & (r_value == MaxVal);

  // Load takes priority over increment; the top never asserts both together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_value <= '0;
    end else if (load_en) begin
      r_value <= load_val;
    end else if (inc) begin
      r_value <= (r_value == MaxVal) ? '0 : r_value + WIDTH'(1);
    end
  end

endmodule

// File: rtl/clock_time_counter.sv
// Time-of-day counter: counts one-second ticks into hh:mm:ss, with a validated load handshake.
module clock_time_counter
  import clock_pkg::*;
#(
  parameter int unsigned HOURS_PER_DAY = 24,
  parameter bit          TICK_EDGE     = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sec_tick,
  input  logic              run_en,
  input  logic              set_valid,
  output logic              set_ready,
  input  logic [HOUR_W-1:0] set_hour,
  input  logic [MIN_W-1:0]  set_min,
  input  logic [SEC_W-1:0]  set_sec,
  output logic [HOUR_W-1:0] hour,
  output logic [MIN_W-1:0]  min,
  output logic [SEC_W-1:0]  sec,
  output logic              sec_pulse,
  output logic              min_pulse,
  output logic              hour_pulse,
  output logic              day_pulse,
  output logic              set_err,
  output logic              running
);

  state_e r_state;
  logic   r_tick_d;
  logic   r_sec_pulse, r_min_pulse, r_hour_pulse, r_day_pulse;
  logic   r_set_err, r_running;

  logic w_tick, w_hs, w_legal, w_load, w_inc;
  logic w_sec_wrap, w_min_wrap, w_hour_wrap;

  assign w_tick    = TICK_EDGE ? (sec_tick & ~r_tick_d) : sec_tick;
  assign set_ready = (r_state != LOAD);
  assign w_hs      = set_valid & set_ready;

  // Compare at 32 bits so HOURS_PER_DAY=32 is not truncated to the 5-bit hour field.
  assign w_legal = ({{(32 - SEC_W){1'b0}}, set_sec} < SEC_PER_MIN) &&
                   ({{(32 - MIN_W){1'b0}}, set_min} < MIN_PER_HOUR) &&
                   ({{(32 - HOUR_W){1'b0}}, set_hour} < HOURS_PER_DAY);
  assign w_load  = w_hs & w_legal;

  // A concurrent load wins, and a tick in the cycle run_en drops is discarded.
  assign w_inc = (r_state == RUN) & w_tick & run_en & ~w_hs;

  mod_counter #(.MODULUS(SEC_PER_MIN), .WIDTH(SEC_W)) u_sec (
    .clk      (clk),
    .rst      (rst),
    .inc      (w_inc),
    .load_en  (w_load),
    .load_val (set_sec),
    .value    (sec),
    .wrap     (w_sec_wrap)
  );

  mod_counter #(.MODULUS(MIN_PER_HOUR), .WIDTH(MIN_W)) u_min (
    .clk      (clk),
    .rst      (rst),
    .inc      (w_sec_wrap),
    .load_en  (w_load),
    .load_val (set_min),
    .value    (min),
    .wrap     (w_min_wrap)
  );

  mod_counter #(.MODULUS(HOURS_PER_DAY), .WIDTH(HOUR_W)) u_hour (
    .clk      (clk),
    .rst      (rst),
    .inc      (w_min_wrap),
    .load_en  (w_load),
    .load_val (set_hour),
    .value    (hour),
    .wrap     (w_hour_wrap)
  );

  assign sec_pulse  = r_sec_pulse;
  assign min_pulse  = r_min_pulse;
  assign hour_pulse = r_hour_pulse;
  assign day_pulse  = r_day_pulse;
  assign set_err    = r_set_err;
  assign running    = r_running;

  // Control FSM plus registered strobes, aligned with the cycle the time registers change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= STOP;
      r_tick_d     <= 1'b0;
      r_running    <= 1'b0;
      r_sec_pulse  <= 1'b0;
      r_min_pulse  <= 1'b0;
      r_hour_pulse <= 1'b0;
      r_day_pulse  <= 1'b0;
      r_set_err    <= 1'b0;
    end else begin
      r_tick_d     <= sec_tick;
      r_sec_pulse  <= w_inc;
      r_min_pulse  <= w_sec_wrap;
      r_hour_pulse <= w_min_wrap;
      r_day_pulse  <= w_hour_wrap;
      r_set_err    <= w_hs & ~w_legal;
      case (r_state)
        STOP: begin
          if (w_hs) begin
            r_state   <= LOAD;
            r_running <= 1'b0;
          end else if (run_en) begin
            r_state   <= RUN;
            r_running <= 1'b1;
          end
        end
        RUN: begin
          if (w_hs) begin
            r_state   <= LOAD;
            r_running <= 1'b0;
          end else if (!run_en) begin
            r_state   <= STOP;
            r_running <= 1'b0;
          end
        end
        default: begin
          r_state   <= STOP;
          r_running <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clock_time_counter.sv
// Bench: edge-mode and level-mode instances driven in parallel, checked against a seconds-of-day model.
module tb_clock_time_counter;

  localparam int HPD = 24;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sec_tick = 1'b0, run_en = 1'b0, set_valid = 1'b0;
  logic [4:0] set_hour = '0;
  logic [5:0] set_min = '0, set_sec = '0;

  logic       ready_e, sp_e, mp_e, hp_e, dp_e, err_e, run_e;
  logic [4:0] hour_e;
  logic [5:0] min_e, sec_e;
  logic       ready_l, sp_l, mp_l, hp_l, dp_l, err_l, run_l;
  logic [4:0] hour_l;
  logic [5:0] min_l, sec_l;

  always #5 clk = ~clk;

  clock_time_counter #(.HOURS_PER_DAY(HPD), .TICK_EDGE(1'b1)) dut_e (
    .clk(clk), .rst(rst), .sec_tick(sec_tick), .run_en(run_en), .set_valid(set_valid),
    .set_ready(ready_e), .set_hour(set_hour), .set_min(set_min), .set_sec(set_sec),
    .hour(hour_e), .min(min_e), .sec(sec_e), .sec_pulse(sp_e), .min_pulse(mp_e),
    .hour_pulse(hp_e), .day_pulse(dp_e), .set_err(err_e), .running(run_e)
  );

  clock_time_counter #(.HOURS_PER_DAY(HPD), .TICK_EDGE(1'b0)) dut_l (
    .clk(clk), .rst(rst), .sec_tick(sec_tick), .run_en(run_en), .set_valid(set_valid),
    .set_ready(ready_l), .set_hour(set_hour), .set_min(set_min), .set_sec(set_sec),
    .hour(hour_l), .min(min_l), .sec(sec_l), .sec_pulse(sp_l), .min_pulse(mp_l),
    .hour_pulse(hp_l), .day_pulse(dp_l), .set_err(err_l), .running(run_l)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_minp   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Model: time as seconds since midnight; mode 0=stopped, 1=running, 2=loading.
  typedef struct {
    int t;
    int mode;
    bit prev;
    bit sp, mp, hp, dp, err;
  } mdl_t;

  mdl_t m_e, m_l;

  function automatic mdl_t reset_model();
    mdl_t r;
    r.t = 0; r.mode = 0; r.prev = 0;
    r.sp = 0; r.mp = 0; r.hp = 0; r.dp = 0; r.err = 0;
    return r;
  endfunction

  function automatic mdl_t step(input mdl_t m, input bit edge_mode, input bit st, input bit re,
                                input bit sv, input int sh, input int smn, input int ss);
    mdl_t r = m;
    bit tick = edge_mode ? (st && !m.prev) : st;
    bit hs   = sv && (m.mode != 2);
    int s    = m.t % 60;
    int mi   = (m.t / 60) % 60;
    r.prev = st;
    r.sp = 0; r.mp = 0; r.hp = 0; r.dp = 0; r.err = 0;
    if (hs) begin
      if (ss < 60 && smn < 60 && sh < HPD) r.t = sh * 3600 + smn * 60 + ss;
      else r.err = 1;
      r.mode = 2;
    end else begin
      if (m.mode == 1 && tick && re) begin
        r.t  = (m.t + 1) % (HPD * 3600);
        r.sp = 1;
        r.mp = (s == 59);
        r.hp = (s == 59 && mi == 59);
        r.dp = (r.t == 0);
      end
      r.mode = (m.mode == 2) ? 0 : (re ? 1 : 0);
    end
    return r;
  endfunction

  function automatic logic [23:0] expv(input mdl_t m);
    return {5'(m.t / 3600), 6'((m.t / 60) % 60), 6'(m.t % 60),
            m.sp, m.mp, m.hp, m.dp, m.err, (m.mode == 1), (m.mode != 2)};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_e = reset_model();
      m_l = reset_model();
    end else begin
      m_e = step(m_e, 1'b1, sec_tick, run_en, set_valid, int'(set_hour), int'(set_min),
                 int'(set_sec));
      m_l = step(m_l, 1'b0, sec_tick, run_en, set_valid, int'(set_hour), int'(set_min),
                 int'(set_sec));
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(posedge clk) begin
    #1;
    check("model_edge", {hour_e, min_e, sec_e, sp_e, mp_e, hp_e, dp_e, err_e, run_e, ready_e},
          expv(m_e));
    check("model_level", {hour_l, min_l, sec_l, sp_l, mp_l, hp_l, dp_l, err_l, run_l, ready_l},
          expv(m_l));
    if (mp_e) n_minp++;
  end

  task automatic do_load(input int h, input int mi, input int s);
    set_hour  = 5'(h);
    set_min   = 6'(mi);
    set_sec   = 6'(s);
    set_valid = 1'b1;
    @(negedge clk);
    set_valid = 1'b0;
  endtask

  initial begin
    int s0_e, s0_l;
    repeat (2) @(negedge clk);
    check("rst_time", {hour_e, min_e, sec_e}, 17'd0);
    check("rst_flags", {ready_e, run_e, err_e, sp_e, mp_e, hp_e, dp_e}, 7'b1000000);
    rst = 1'b0;
    run_en = 1'b1;
    repeat (2) @(negedge clk);
    check("run_after_rst", run_e, 1'b1);

    // 60 single-cycle ticks, 10 cycles apart
    n_minp = 0;
    for (int i = 0; i < 60; i++) begin
      sec_tick = 1'b1;
      @(negedge clk);
      sec_tick = 1'b0;
      repeat (9) @(negedge clk);
    end
    check("min_roll_time", {hour_e, min_e, sec_e}, {5'd0, 6'd1, 6'd0});
    check("min_roll_count", n_minp, 1);
    check("min_roll_level", {hour_l, min_l, sec_l}, {5'd0, 6'd1, 6'd0});
    check("model_pin_60", m_e.t, 60);

    // Full carry chain from 23:59:59
    do_load(23, 59, 59);
    check("load_time", {hour_e, min_e, sec_e}, {5'd23, 6'd59, 6'd59});
    check("load_ready", {ready_e, run_e}, 2'b00);
    repeat (2) @(negedge clk);
    sec_tick = 1'b1;
    @(negedge clk);
    sec_tick = 1'b0;
    check("day_wrap_time", {hour_e, min_e, sec_e}, 17'd0);
    check("day_wrap_pulses", {sp_e, mp_e, hp_e, dp_e}, 4'b1111);
    check("day_wrap_pulses_l", {sp_l, mp_l, hp_l, dp_l}, 4'b1111);

    // Illegal load: minutes = 60
    do_load(1, 60, 3);
    check("bad_load_err", {err_e, ready_e, run_e}, 3'b100);
    check("bad_load_time", {hour_e, min_e, sec_e}, 17'd0);
    @(negedge clk);
    check("bad_load_stop", {err_e, ready_e, run_e}, 3'b010);
    @(negedge clk);
    check("bad_load_resume", run_e, 1'b1);

    // Held tick: edge mode counts once, level mode counts every cycle
    s0_e = int'(sec_e);
    s0_l = int'(sec_l);
    sec_tick = 1'b1;
    repeat (5) @(negedge clk);
    sec_tick = 1'b0;
    repeat (2) @(negedge clk);
    check("held_tick_edge", int'(sec_e) - s0_e, 1);
    check("held_tick_level", int'(sec_l) - s0_l, 5);

    // Load and tick in the same cycle: load wins
    sec_tick = 1'b1;
    do_load(12, 0, 0);
    sec_tick = 1'b0;
    check("load_vs_tick", {hour_e, min_e, sec_e, sp_e}, {5'd12, 6'd0, 6'd0, 1'b0});
    check("load_vs_tick_l", {hour_l, min_l, sec_l, sp_l}, {5'd12, 6'd0, 6'd0, 1'b0});
    repeat (2) @(negedge clk);
    sec_tick = 1'b1;
    @(negedge clk);
    sec_tick = 1'b0;
    check("after_load_tick", {hour_e, min_e, sec_e}, {5'd12, 6'd0, 6'd1});

    // Tick in the cycle run_en falls is dropped
    sec_tick = 1'b1;
    run_en = 1'b0;
    @(negedge clk);
    sec_tick = 1'b0;
    check("run_fall_tick", {sec_e, sp_e, run_e}, {6'd1, 1'b0, 1'b0});
    run_en = 1'b1;
    repeat (2) @(negedge clk);

    // Asynchronous reset between clock edges
    do_load(5, 6, 7);
    repeat (2) @(negedge clk);
    check("pre_rst_time", {hour_e, min_e, sec_e}, {5'd5, 6'd6, 6'd7});
    #2 rst = 1'b1;
    #1;
    check("async_rst_time", {hour_e, min_e, sec_e, hour_l, min_l, sec_l}, 34'd0);
    check("async_rst_flags", {ready_e, run_e, sp_e, err_e}, 4'b1000);
    @(negedge clk);
    rst = 1'b0;
    check("post_rst_ready", {ready_e, run_e}, 2'b10);

    // Randomised traffic, including occasional illegal loads and reset pulses
    for (int i = 0; i < 3000; i++) begin
      sec_tick  = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 19) == 0) run_en = ~run_en;
      set_valid = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 1) == 0) begin
        set_hour = 5'($urandom_range(0, 31));
        set_min  = 6'($urandom_range(0, 63));
        set_sec  = 6'($urandom_range(0, 63));
      end else begin
        set_hour = 5'($urandom_range(22, 23));
        set_min  = 6'($urandom_range(58, 59));
        set_sec  = 6'($urandom_range(55, 59));
      end
      if ($urandom_range(0, 499) == 0) begin
        #2 rst = 1'b1;
        #6 rst = 1'b0;
      end
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
